// File: rtl/processor_core.sv
// Five-stage in-order RV64I-subset pipeline (IF, ID, EX, MEM, WB) with internal
// instruction ROM, data RAM, operand forwarding, load-use stalling and beq resolved in EX.
module processor_core #(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 64,
    parameter string IMEM_FILE  = "instructions.mem",
    parameter string DMEM_FILE  = "data.mem"
) (
    input  logic clk,
    input  logic rst_n
);

    localparam int IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    logic [31:0] r_imem [0:IMEM_DEPTH-1];
    logic [63:0] r_dmem [0:DMEM_DEPTH-1];

    logic [31:0] pc;
    logic [63:0] register_file [0:31];
    logic [31:0] if_instruction;
    logic [63:0] ex_alu_result;
    logic [63:0] mem_data;

    // IF/ID
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;

    // ID/EX
    logic [31:0] r_idex_pc;
    logic [63:0] r_idex_rs1_val;
    logic [63:0] r_idex_rs2_val;
    logic [63:0] r_idex_imm;
    logic [4:0]  r_idex_rs1;
    logic [4:0]  r_idex_rs2;
    logic [4:0]  r_idex_rd;
    logic        r_idex_regwrite;
    logic        r_idex_memread;
    logic        r_idex_memwrite;
    logic        r_idex_branch;
    logic        r_idex_alusrc;
    logic [1:0]  r_idex_aluop;

    // EX/MEM (ex_alu_result is the latched ALU result)
    logic [63:0] r_exmem_store_data;
    logic [4:0]  r_exmem_rd;
    logic        r_exmem_regwrite;
    logic        r_exmem_memread;
    logic        r_exmem_memwrite;

    // MEM/WB
    logic [63:0] r_memwb_data;
    logic [4:0]  r_memwb_rd;
    logic        r_memwb_regwrite;

    logic [31:0]        w_fetch_word;
    logic [IMEM_AW-1:0] w_imem_idx;

    assign w_fetch_word   = {2'b00, pc[31:2]};
    assign w_imem_idx     = IMEM_AW'(w_fetch_word % 32'(IMEM_DEPTH));
    assign if_instruction = r_imem[w_imem_idx];

    logic [6:0]  w_id_opcode;
    logic [2:0]  w_id_funct3;
    logic [6:0]  w_id_funct7;
    logic [4:0]  w_id_rs1;
    logic [4:0]  w_id_rs2;
    logic [4:0]  w_id_rd;
    logic        w_id_regwrite;
    logic        w_id_memread;
    logic        w_id_memwrite;
    logic        w_id_branch;
    logic        w_id_alusrc;
    logic [1:0]  w_id_aluop;
    logic [63:0] w_id_imm;
    logic [63:0] w_id_rs1_val;
    logic [63:0] w_id_rs2_val;

    assign w_id_opcode = r_ifid_instr[6:0];
    assign w_id_rd     = r_ifid_instr[11:7];
    assign w_id_funct3 = r_ifid_instr[14:12];
    assign w_id_rs1    = r_ifid_instr[19:15];
    assign w_id_rs2    = r_ifid_instr[24:20];
    assign w_id_funct7 = r_ifid_instr[31:25];

    // Anything not explicitly recognised leaves every control at zero and becomes a NOP.
    always_comb begin
        w_id_regwrite = 1'b0;
        w_id_memread  = 1'b0;
        w_id_memwrite = 1'b0;
        w_id_branch   = 1'b0;
        w_id_alusrc   = 1'b0;
        w_id_aluop    = ALU_ADD;
        w_id_imm      = 64'd0;
        case (w_id_opcode)
            OP_RTYPE: begin
                if (w_id_funct3 == 3'b000 && w_id_funct7 == 7'b0000000) begin
                    w_id_regwrite = 1'b1;
                    w_id_aluop    = ALU_ADD;
                end else if (w_id_funct3 == 3'b000 && w_id_funct7 == 7'b0100000) begin
                    w_id_regwrite = 1'b1;
                    w_id_aluop    = ALU_SUB;
                end else if (w_id_funct3 == 3'b111 && w_id_funct7 == 7'b0000000) begin
                    w_id_regwrite = 1'b1;
                    w_id_aluop    = ALU_AND;
                end else if (w_id_funct3 == 3'b110 && w_id_funct7 == 7'b0000000) begin
                    w_id_regwrite = 1'b1;
                    w_id_aluop    = ALU_OR;
                end
            end
            OP_IMM: begin
                if (w_id_funct3 == 3'b000) begin
                    w_id_regwrite = 1'b1;
                    w_id_alusrc   = 1'b1;
                    w_id_imm      = {{52{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
                end
            end
            OP_LOAD: begin
                if (w_id_funct3 == 3'b011) begin
                    w_id_regwrite = 1'b1;
                    w_id_memread  = 1'b1;
                    w_id_alusrc   = 1'b1;
                    w_id_imm      = {{52{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
                end
            end
            OP_STORE: begin
                if (w_id_funct3 == 3'b011) begin
                    w_id_memwrite = 1'b1;
                    w_id_alusrc   = 1'b1;
                    w_id_imm      = {{52{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
                end
            end
            OP_BRANCH: begin
                if (w_id_funct3 == 3'b000) begin
                    w_id_branch = 1'b1;
                    w_id_imm    = {{51{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                                   r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Register reads see a same-cycle WB write to the same register.
    assign w_id_rs1_val = (w_id_rs1 == 5'd0) ? 64'd0 :
                          (r_memwb_regwrite && r_memwb_rd == w_id_rs1) ? r_memwb_data :
                          register_file[w_id_rs1];
    assign w_id_rs2_val = (w_id_rs2 == 5'd0) ? 64'd0 :
                          (r_memwb_regwrite && r_memwb_rd == w_id_rs2) ? r_memwb_data :
                          register_file[w_id_rs2];

    logic w_load_use;
    assign w_load_use = r_idex_memread && (r_idex_rd != 5'd0) &&
                        ((r_idex_rd == w_id_rs1) || (r_idex_rd == w_id_rs2));

    logic [63:0] w_fwd_a;
    logic [63:0] w_fwd_b;
    logic [63:0] w_alu_b;
    logic [63:0] w_alu_out;
    logic        w_branch_taken;
    logic [31:0] w_branch_target;

    // The younger producer (EX/MEM) takes priority over MEM/WB.
    assign w_fwd_a = (r_exmem_regwrite && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs1) ? ex_alu_result :
                     (r_memwb_regwrite && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs1) ? r_memwb_data :
                     r_idex_rs1_val;
    assign w_fwd_b = (r_exmem_regwrite && r_exmem_rd != 5'd0 && r_exmem_rd == r_idex_rs2) ? ex_alu_result :
                     (r_memwb_regwrite && r_memwb_rd != 5'd0 && r_memwb_rd == r_idex_rs2) ? r_memwb_data :
                     r_idex_rs2_val;

    assign w_alu_b = r_idex_alusrc ? r_idex_imm : w_fwd_b;

    always_comb begin
        w_alu_out = 64'd0;
        case (r_idex_aluop)
            ALU_ADD: w_alu_out = w_fwd_a + w_alu_b;
            ALU_SUB: w_alu_out = w_fwd_a - w_alu_b;
            ALU_AND: w_alu_out = w_fwd_a & w_alu_b;
            ALU_OR:  w_alu_out = w_fwd_a | w_alu_b;
            default: w_alu_out = 64'd0;
        endcase
    end

    assign w_branch_taken  = r_idex_branch && (w_fwd_a == w_fwd_b);
    assign w_branch_target = r_idex_pc + r_idex_imm[31:0];

    logic [DMEM_AW-1:0] w_dmem_idx;
    assign w_dmem_idx = DMEM_AW'({3'b000, ex_alu_result[63:3]} % 64'(DMEM_DEPTH));
    assign mem_data   = r_exmem_memread ? r_dmem[w_dmem_idx] : 64'd0;

    logic w_unused_bits;
    assign w_unused_bits = ^{pc[1:0], ex_alu_result[2:0]};

    // A taken branch overrides a load-use stall; a stall freezes pc and IF/ID.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= 32'd0;
            r_ifid_instr <= 32'd0;
            r_ifid_pc    <= 32'd0;
        end else if (w_branch_taken) begin
            pc           <= w_branch_target;
            r_ifid_instr <= 32'd0;
            r_ifid_pc    <= 32'd0;
        end else if (!w_load_use) begin
            pc           <= pc + 32'd4;
            r_ifid_instr <= if_instruction;
            r_ifid_pc    <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_branch_taken || w_load_use) begin
            r_idex_pc       <= 32'd0;
            r_idex_rs1_val  <= 64'd0;
            r_idex_rs2_val  <= 64'd0;
            r_idex_imm      <= 64'd0;
            r_idex_rs1      <= 5'd0;
            r_idex_rs2      <= 5'd0;
            r_idex_rd       <= 5'd0;
            r_idex_regwrite <= 1'b0;
            r_idex_memread  <= 1'b0;
            r_idex_memwrite <= 1'b0;
            r_idex_branch   <= 1'b0;
            r_idex_alusrc   <= 1'b0;
            r_idex_aluop    <= ALU_ADD;
        end else begin
            r_idex_pc       <= r_ifid_pc;
            r_idex_rs1_val  <= w_id_rs1_val;
            r_idex_rs2_val  <= w_id_rs2_val;
            r_idex_imm      <= w_id_imm;
            r_idex_rs1      <= w_id_rs1;
            r_idex_rs2      <= w_id_rs2;
            r_idex_rd       <= w_id_rd;
            r_idex_regwrite <= w_id_regwrite;
            r_idex_memread  <= w_id_memread;
            r_idex_memwrite <= w_id_memwrite;
            r_idex_branch   <= w_id_branch;
            r_idex_alusrc   <= w_id_alusrc;
            r_idex_aluop    <= w_id_aluop;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_alu_result      <= 64'd0;
            r_exmem_store_data <= 64'd0;
            r_exmem_rd         <= 5'd0;
            r_exmem_regwrite   <= 1'b0;
            r_exmem_memread    <= 1'b0;
            r_exmem_memwrite   <= 1'b0;
            r_memwb_data       <= 64'd0;
            r_memwb_rd         <= 5'd0;
            r_memwb_regwrite   <= 1'b0;
        end else begin
            ex_alu_result      <= w_alu_out;
            r_exmem_store_data <= w_fwd_b;
            r_exmem_rd         <= r_idex_rd;
            r_exmem_regwrite   <= r_idex_regwrite;
            r_exmem_memread    <= r_idex_memread;
            r_exmem_memwrite   <= r_idex_memwrite;
            r_memwb_data       <= r_exmem_memread ? mem_data : ex_alu_result;
            r_memwb_rd         <= r_exmem_rd;
            r_memwb_regwrite   <= r_exmem_regwrite;
        end
    end

    // The RAM is never cleared, but a store caught in flight by reset must not land.
    always_ff @(posedge clk) begin
        if (rst_n && r_exmem_memwrite) begin
            r_dmem[w_dmem_idx] <= r_exmem_store_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                register_file[i] <= 64'd0;
            end
        end else if (r_memwb_regwrite && r_memwb_rd != 5'd0) begin
            register_file[r_memwb_rd] <= r_memwb_data;
        end
    end

endmodule

// File: tb/tb_processor_core.sv
// Self-checking bench for processor_core: directed timing checks plus random programs
// compared against an instruction-level reference model.
module tb_processor_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    processor_core #(
        .IMEM_DEPTH(64),
        .DMEM_DEPTH(64),
        .IMEM_FILE(""),
        .DMEM_FILE("")
    ) dut (
        .clk(clk),
        .rst_n(rst_n)
    );

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_LD, K_SD, K_BEQ, K_NOP} kind_e;

    typedef struct {
        kind_e  kind;
        int     rd;
        int     rs1;
        int     rs2;
        longint imm;
    } op_t;

    op_t         progOp[64];
    logic [31:0] progWord[64];
    int          progLen;
    int          haltIdx;
    logic [63:0] modelReg[32];
    logic [63:0] modelMem[64];
    int          totalChecks = 0;
    int          badChecks = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void emitRaw(input logic [31:0] word);
        progOp[progLen].kind = K_NOP;
        progOp[progLen].rd   = 0;
        progOp[progLen].rs1  = 0;
        progOp[progLen].rs2  = 0;
        progOp[progLen].imm  = 0;
        progWord[progLen]    = word;
        progLen++;
    endfunction

    function automatic void emit(input kind_e k, input int rd, input int rs1, input int rs2, input longint imm);
        logic [63:0] immBits;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] w;
        immBits = 64'(imm);
        d  = 5'(rd);
        s1 = 5'(rs1);
        s2 = 5'(rs2);
        case (k)
            K_ADD:  w = {7'h00, s2, s1, 3'b000, d, 7'b0110011};
            K_SUB:  w = {7'h20, s2, s1, 3'b000, d, 7'b0110011};
            K_AND:  w = {7'h00, s2, s1, 3'b111, d, 7'b0110011};
            K_OR:   w = {7'h00, s2, s1, 3'b110, d, 7'b0110011};
            K_ADDI: w = {immBits[11:0], s1, 3'b000, d, 7'b0010011};
            K_LD:   w = {immBits[11:0], s1, 3'b011, d, 7'b0000011};
            K_SD:   w = {immBits[11:5], s2, s1, 3'b011, immBits[4:0], 7'b0100011};
            K_BEQ:  w = {immBits[12], immBits[10:5], s2, s1, 3'b000, immBits[4:1], immBits[11], 7'b1100011};
            default: w = 32'd0;
        endcase
        progOp[progLen].kind = k;
        progOp[progLen].rd   = rd;
        progOp[progLen].rs1  = rs1;
        progOp[progLen].rs2  = rs2;
        progOp[progLen].imm  = imm;
        progWord[progLen]    = w;
        progLen++;
    endfunction

    // Architectural execution, one whole instruction at a time, until the self-loop halt.
    task automatic runModel();
        int idx = 0;
        int steps = 0;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] addr;
        for (int r = 0; r < 32; r++) modelReg[r] = 64'd0;
        for (int m = 0; m < 64; m++) modelMem[m] = 64'd0;
        while (idx != haltIdx && steps < 500) begin
            op_t op;
            int next;
            op = progOp[idx];
            a = modelReg[op.rs1];
            b = modelReg[op.rs2];
            addr = a + 64'(op.imm);
            next = idx + 1;
            case (op.kind)
                K_ADD:  if (op.rd != 0) modelReg[op.rd] = a + b;
                K_SUB:  if (op.rd != 0) modelReg[op.rd] = a - b;
                K_AND:  if (op.rd != 0) modelReg[op.rd] = a & b;
                K_OR:   if (op.rd != 0) modelReg[op.rd] = a | b;
                K_ADDI: if (op.rd != 0) modelReg[op.rd] = addr;
                K_LD:   if (op.rd != 0) modelReg[op.rd] = modelMem[int'((addr >> 3) % 64)];
                K_SD:   modelMem[int'((addr >> 3) % 64)] = b;
                K_BEQ:  if (a == b) next = idx + int'(op.imm / 4);
                default: ;
            endcase
            idx = next;
            steps++;
        end
        if (idx != haltIdx) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL model halt: got idx %0d expected %0d", idx, haltIdx);
        end
    endtask

    task automatic stepEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) begin
            dut.r_imem[i] = (i < progLen) ? progWord[i] : 32'd0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic checkRegsZero(input string tag);
        logic [63:0] acc = 64'd0;
        for (int r = 0; r < 32; r++) acc |= dut.register_file[r];
        checkOutput(tag, acc, 64'd0);
    endtask

    task automatic checkFinal(input string tag, input int memLo, input int memHi);
        for (int r = 0; r < 32; r++) begin
            checkOutput($sformatf("%s x%0d", tag, r), dut.register_file[r], modelReg[r]);
        end
        for (int m = memLo; m <= memHi; m++) begin
            checkOutput($sformatf("%s mem[%0d]", tag, m), dut.r_dmem[m], modelMem[m]);
        end
    endtask

    task automatic buildDirected();
        progLen = 0;
        emit(K_ADDI, 1, 0, 0, 5);
        emit(K_ADDI, 2, 0, 0, 7);
        emit(K_ADDI, 3, 0, 0, -1);
        emit(K_ADDI, 4, 0, 0, 3);
        emit(K_ADD, 5, 1, 2, 0);
        emit(K_SUB, 7, 5, 4, 0);
        emit(K_AND, 8, 7, 2, 0);
        emit(K_SD, 0, 0, 5, 8);
        emit(K_LD, 6, 0, 0, 8);
        emit(K_ADD, 9, 6, 6, 0);
        emit(K_BEQ, 0, 1, 1, 8);
        emit(K_ADDI, 10, 0, 0, 1);
        emit(K_BEQ, 0, 1, 2, 8);
        emit(K_ADDI, 10, 0, 0, 1);
        emit(K_ADDI, 0, 0, 0, 9);
        emitRaw(32'hFFFF_FFFF);
        emitRaw(32'h0000_0000);
        haltIdx = progLen;
        emit(K_BEQ, 0, 0, 0, 0);
    endtask

    task automatic buildRandom(input int nRand);
        logic [31:0] raw;
        progLen = 0;
        for (int k = 0; k < 8; k++) emit(K_SD, 0, 0, 0, k * 8);
        haltIdx = 8 + nRand;
        for (int i = 0; i < nRand; i++) begin
            int sel = int'($urandom_range(0, 11));
            int rd  = int'($urandom_range(0, 7));
            int rs1 = int'($urandom_range(0, 7));
            int rs2 = int'($urandom_range(0, 7));
            int memOff = int'($urandom_range(0, 7)) * 8 + int'($urandom_range(0, 7));
            int pos = progLen;
            case (sel)
                0: emit(K_ADD, rd, rs1, rs2, 0);
                1: emit(K_SUB, rd, rs1, rs2, 0);
                2: emit(K_AND, rd, rs1, rs2, 0);
                3: emit(K_OR, rd, rs1, rs2, 0);
                4, 5: emit(K_ADDI, rd, rs1, 0, longint'(int'($urandom_range(0, 4095)) - 2048));
                6: emit(K_LD, rd, 0, 0, memOff);
                7: emit(K_SD, 0, 0, rs2, memOff);
                8: emit(K_BEQ, 0, rs1 % 4, rs2 % 4,
                         longint'((int'($urandom_range(pos + 1, haltIdx)) - pos) * 4));
                9: emitRaw(32'd0);
                10: begin
                    raw = $urandom;
                    raw[6:0] = 7'b0110111;
                    emitRaw(raw);
                end
                default: emitRaw({7'b0000001, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011});
            endcase
        end
        emit(K_BEQ, 0, 0, 0, 0);
    endtask

    initial begin
        buildDirected();
        runModel();
        applyStimulus();

        checkOutput("reset pc", 64'(dut.pc), 64'd0);
        checkOutput("reset if_instruction", 64'(dut.if_instruction), 64'(progWord[0]));
        checkOutput("reset ex_alu_result", dut.ex_alu_result, 64'd0);
        checkOutput("reset mem_data", dut.mem_data, 64'd0);
        checkRegsZero("reset regs");

        // Edge-exact writeback times: independent ops, forwarding, one load-use bubble, taken branch.
        stepEdges(8);
        checkOutput("e8 x1", dut.register_file[1], 64'd5);
        checkOutput("e8 x2", dut.register_file[2], 64'd7);
        checkOutput("e8 x3", dut.register_file[3], 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("e8 x4", dut.register_file[4], 64'd3);
        checkOutput("e8 x0", dut.register_file[0], 64'd0);
        stepEdges(2);
        checkOutput("e10 x5", dut.register_file[5], 64'd12);
        checkOutput("e10 x7", dut.register_file[7], 64'd9);
        stepEdges(1);
        checkOutput("e11 x8", dut.register_file[8], 64'd1);
        checkOutput("e11 mem1", dut.r_dmem[1], 64'd12);
        stepEdges(2);
        checkOutput("e13 x6", dut.register_file[6], 64'd12);
        stepEdges(1);
        checkOutput("e14 x9 early", dut.register_file[9], 64'd0);
        stepEdges(1);
        checkOutput("e15 x9", dut.register_file[9], 64'd24);
        stepEdges(4);
        checkOutput("e19 x10 early", dut.register_file[10], 64'd0);
        stepEdges(1);
        checkOutput("e20 x10", dut.register_file[10], 64'd1);
        stepEdges(40);
        checkFinal("directed", 1, 1);

        // Reset while instruction 4 sits in EX/MEM and instruction 3 is about to write back.
        applyStimulus();
        stepEdges(7);
        rst_n = 1'b0;
        stepEdges(1);
        checkOutput("midreset pc", 64'(dut.pc), 64'd0);
        checkOutput("midreset x4", dut.register_file[4], 64'd0);
        checkRegsZero("midreset regs");
        rst_n = 1'b1;
        stepEdges(60);
        checkFinal("rerun", 1, 1);

        for (int p = 0; p < 6; p++) begin
            buildRandom(30);
            runModel();
            applyStimulus();
            stepEdges(3 * progLen + 20);
            checkFinal($sformatf("rand%0d", p), 0, 7);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
